// File: rtl/cdr_lock_sequencer_if.sv
// Lane-side bundle between link training, the CDR and cdr_lock_sequencer.
// Latency: none (wires only).
// Backpressure: none; level and pulse signals only. CDR_SEQ_STATS_EN adds the stats outputs.
interface cdr_lock_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  logic               enable;
  logic               cdr_lock;
  logic               cdr_rst_n;
  logic               link_up;
  logic               fail;
  logic               relock_pulse;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_o;
`ifdef CDR_SEQ_STATS_EN
  logic [15:0]        lock_loss_cnt;
  logic [15:0]        lock_time_cyc;

  modport master (
    output enable, cdr_lock,
    input  cdr_rst_n, link_up, fail, relock_pulse, retry_cnt, state_o,
    input  lock_loss_cnt, lock_time_cyc
  );
  modport slave (
    input  enable, cdr_lock,
    output cdr_rst_n, link_up, fail, relock_pulse, retry_cnt, state_o,
    output lock_loss_cnt, lock_time_cyc
  );
`else
  modport master (
    output enable, cdr_lock,
    input  cdr_rst_n, link_up, fail, relock_pulse, retry_cnt, state_o
  );
  modport slave (
    input  enable, cdr_lock,
    output cdr_rst_n, link_up, fail, relock_pulse, retry_cnt, state_o
  );
`endif
endinterface

// File: rtl/cdr_lock_sequencer.sv
// Per-lane CDR bring-up: reset hold, lock wait/qualify, loss filter, bounded retries.
// Latency: cdr_lock -> decision 2 cycles (synchronizer); all outputs registered, 1 cycle after decision.
// Backpressure: none; enable=0 aborts to IDLE at once. CDR_SEQ_STATS_EN adds lock_loss_cnt/lock_time_cyc.
module cdr_lock_sequencer #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 4096,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int UNLOCK_FILTER    = 4,
  parameter int MAX_RETRIES      = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  cdr_lock_sequencer_if.slave bus
);
  localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (LOCK_STABLE_CYC > UNLOCK_FILTER) ? LOCK_STABLE_CYC : UNLOCK_FILTER;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_LOCKED = 3'd4,
    S_FAILED = 3'd5
  } state_t;

  logic               lock_meta;
  logic               lock_s;
  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_nxt;
  logic               relock_nxt;
  logic               cdr_rst_n_q;
  logic               link_up_q;
  logic               fail_q;
  logic               relock_q;

  // Two-flop synchronizer for the CDR lock, which is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.cdr_lock;
      lock_s    <= lock_meta;
    end
  end

  // State, shared phase counter and retry count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
    end
  end

  // Next-state logic; enable=0 overrides everything, cnt clears on any state change
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q + CNT_W'(1);
    retry_nxt  = retry_q;
    relock_nxt = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.enable) begin
          state_nxt = S_RESET;
          retry_nxt = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == CNT_W'(RST_HOLD_CYC - 1)) state_nxt = S_RESET == S_RESET ? S_WAIT : S_WAIT;
      end
      S_WAIT: begin
        // lock beats a timeout expiring in the same cycle
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_nxt = retry_q + RETRY_W'(1);
          state_nxt = (retry_q < RETRY_W'(MAX_RETRIES)) ? S_RESET : S_FAILED;
        end
      end
      S_STABLE: begin
        // a dropout only restarts the wait; it is not a failed attempt
        if (!lock_s) state_nxt = S_WAIT;
        else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        // cnt tracks the current run of unlocked cycles
        if (lock_s) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_W'(UNLOCK_FILTER - 1)) begin
          state_nxt  = S_RESET;
          relock_nxt = 1'b1;
          retry_nxt  = '0;
        end
      end
      S_FAILED: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (!bus.enable) begin
      state_nxt  = S_IDLE;
      retry_nxt  = '0;
      relock_nxt = 1'b0;
    end
    if (state_nxt != state_q) cnt_nxt = '0;
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdr_rst_n_q <= 1'b0;
      link_up_q   <= 1'b0;
      fail_q      <= 1'b0;
      relock_q    <= 1'b0;
    end else begin
      cdr_rst_n_q <= (state_nxt == S_WAIT) || (state_nxt == S_STABLE) || (state_nxt == S_LOCKED);
      link_up_q   <= (state_nxt == S_LOCKED);
      fail_q      <= (state_nxt == S_FAILED);
      relock_q    <= relock_nxt;
    end
  end

  assign bus.cdr_rst_n    = cdr_rst_n_q;
  assign bus.link_up      = link_up_q;
  assign bus.fail         = fail_q;
  assign bus.relock_pulse = relock_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.state_o      = state_q;

`ifdef CDR_SEQ_STATS_EN
  logic [15:0] loss_q;
  logic [15:0] acq_tmr_q;
  logic [15:0] lock_time_q;

  // Saturating loss counter and acquisition timer (WAIT+STABLE time of an attempt)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q      <= '0;
      acq_tmr_q   <= '0;
      lock_time_q <= '0;
    end else begin
      if (relock_nxt && (loss_q != 16'hFFFF)) loss_q <= loss_q + 16'd1;
      if (state_q == S_RESET) begin
        acq_tmr_q <= '0;
      end else if (((state_q == S_WAIT) || (state_q == S_STABLE)) && (acq_tmr_q != 16'hFFFF)) begin
        acq_tmr_q <= acq_tmr_q + 16'd1;
      end
      if ((state_q == S_STABLE) && (state_nxt == S_LOCKED)) begin
        lock_time_q <= (acq_tmr_q == 16'hFFFF) ? 16'hFFFF : acq_tmr_q + 16'd1;
      end
    end
  end

  assign bus.lock_loss_cnt = loss_q;
  assign bus.lock_time_cyc = lock_time_q;
`endif
endmodule
